multicycle_controller: RTL and testbench
========================================

# multicycle_controller

Moore-style sequencing FSM for the multicycle MIPS datapath. It replaces the single-cycle opcode decode with a per-instruction state sequence: FETCH, DECODE, then execute/memory/writeback. It drives every datapath mux and write enable, and stalls on a shared instruction/data memory through a ready handshake. Supported opcodes: R-type, lw, sw, beq, addi and j; any other opcode is flagged and skipped.

## Interface
Parameters: none.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  reset. Synchronous and active-high: rst_n=1 resets (the name is the codebase's port name, not its polarity).
- Opcode  in  6  instruction[31:26], taken from the IR register; stable from DECODE until the next FETCH.
- mem_ready  in  1  memory has completed the current read or write this cycle.
- PCWrite  out  1  unconditional PC load.
- Branch  out  1  conditional PC load, qualified by ALU zero in the datapath.
- IorD  out  1  memory address source: 0=PC, 1=ALUOut.
- MemRead  out  1  memory read request.
- MemWrite  out  1  memory write request.
- IRWrite  out  1  load the instruction register.
- MemtoReg  out  1  register write-data source: 0=ALUOut, 1=MDR.
- RegDst  out  1  destination register: 0=rt, 1=rd.
- RegWrite  out  1  register file write.
- ALUSrcA  out  1  ALU A source: 0=PC, 1=rs.
- ALUSrcB  out  2  ALU B source: 00=rt, 01=4, 10=sign-extended imm, 11=sign-extended imm<<2.
- ALUOp  out  2  ALU op class: 00=add, 01=sub, 10=funct.
- PCSrc  out  2  next-PC source: 00=ALU result, 01=ALUOut, 10=jump target.
- instr_done  out  1  high in the final cycle of each instruction.
- illegal_op  out  1  high in a DECODE cycle whose Opcode is unsupported.

## Operation
- State register, 4 bits. The next-state and output decode are combinational from the state, Opcode and mem_ready.
- Any output not listed for a state is 0.

States and outputs:
- FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSrc=00, IRWrite=PCWrite=mem_ready.
  - Goes to DECODE when mem_ready=1; otherwise holds.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00 (precomputes the branch target).
  - Next state by opcode: lw/sw→MEMADR, R-type→EXEC, beq→BRANCH, addi→ADDIEX, j→JUMP.
  - Any other opcode: illegal_op=1, instr_done=1, next state FETCH.
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next state MEMRD for lw, MEMWR for sw.
- MEMRD: MemRead=1, IorD=1. Goes to MEMWB on mem_ready; otherwise holds.
- MEMWB: RegDst=0, MemtoReg=1, RegWrite=1, instr_done=1. Next state FETCH.
- MEMWR: MemWrite=1, IorD=1, instr_done=mem_ready. Goes to FETCH on mem_ready; otherwise holds.
- EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Next state ALUWB.
- ALUWB: RegDst=1, MemtoReg=0, RegWrite=1, instr_done=1. Next state FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, Branch=1, PCSrc=01, instr_done=1. Next state FETCH.
- ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next state ADDIWB.
- ADDIWB: RegDst=0, MemtoReg=0, RegWrite=1, instr_done=1. Next state FETCH.
- JUMP: PCWrite=1, PCSrc=10, instr_done=1. Next state FETCH.
- Unused state encodings go to FETCH on the next edge, with all outputs 0.

## Timing
- Reset: any cycle with rst_n=1 forces all outputs to 0 and loads state FETCH at the edge. The first fetch request appears in the cycle after rst_n falls.
- Reset mid-instruction, including during a memory stall, aborts the instruction. No write enable is asserted in the cycle where rst_n=1.
- Memory handshake:
  - MemRead/MemWrite and the address select are held constant until the cycle in which mem_ready=1.
  - Writes qualified by ready (IRWrite, PCWrite in FETCH) fire only in that cycle.
  - mem_ready outside FETCH, MEMRD and MEMWR is ignored.
- Latency with zero wait states (mem_ready=1 in the first request cycle):
  - beq=3, j=3, R-type=4, addi=4, sw=4, lw=5 cycles.
  - Each wait cycle in FETCH, MEMRD or MEMWR adds one cycle.
- instr_done is a single-cycle pulse per instruction. The next FETCH starts on the following cycle.

## Structure
- Shared package `mips_ctrl_pkg` holds:
  - opcode constants: RTYPE=000000, LW=100011, SW=101011, BEQ=000100, ADDI=001000, J=000010;
  - state encodings;
  - ALUOp, ALUSrcB and PCSrc encodings.
- The same opcode constants are used by the existing single-cycle decode.
- Single module; no sub-module.

## Test plan
- Reset: hold rst_n=1 for 3 cycles with mem_ready=1 → all outputs 0. After release, FETCH cycle shows MemRead=1, IRWrite=PCWrite=1.
- lw, zero wait: state sequence FETCH, DECODE, MEMADR, MEMRD, MEMWB; RegWrite=1 with MemtoReg=1 and RegDst=0 in cycle 5; instr_done only in cycle 5.
- sw with mem_ready low for 2 cycles in MEMWR: MemWrite=1 and IorD=1 held for 3 cycles; instr_done in the 3rd; total 6 cycles.
- FETCH stalled 4 cycles: IRWrite=PCWrite=0 until mem_ready=1, then both high for exactly 1 cycle.
- beq, then j, then R-type back to back: 3, 3 and 4 cycles. Check Branch=1/PCSrc=01/ALUOp=01, then PCWrite=1/PCSrc=10, then ALUOp=10 followed by RegDst=1/RegWrite=1.
- Opcode=111111 in DECODE → illegal_op=1 and instr_done=1 for one cycle, no write enables, FETCH next. Also assert rst_n during a MEMRD stall → state FETCH and no RegWrite.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - opcode, state and datapath-select encodings for the MIPS controllers
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
  } state_e;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } alu_op_e;

  typedef enum logic [1:0] {
    SRCB_RT     = 2'b00,
    SRCB_FOUR   = 2'b01,
    SRCB_IMM    = 2'b10,
    SRCB_IMM_SH = 2'b11
  } alu_src_b_e;

  typedef enum logic [1:0] {
    PCSRC_ALU    = 2'b00,
    PCSRC_ALUOUT = 2'b01,
    PCSRC_JUMP   = 2'b10
  } pc_src_e;

endpackage

// File: rtl/multicycle_controller_if.sv
// rtl/multicycle_controller_if.sv - controller <-> datapath/memory control bundle
interface multicycle_controller_if;
  logic [5:0] Opcode;
  logic       mem_ready;
  logic       PCWrite;
  logic       Branch;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       IRWrite;
  logic       MemtoReg;
  logic       RegDst;
  logic       RegWrite;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ALUOp;
  logic [1:0] PCSrc;
  logic       instr_done;
  logic       illegal_op;

  modport master (
    input  Opcode, mem_ready,
    output PCWrite, Branch, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst,
           RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSrc, instr_done, illegal_op
  );

  modport slave (
    output Opcode, mem_ready,
    input  PCWrite, Branch, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst,
           RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSrc, instr_done, illegal_op
  );
endinterface

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - Moore sequencing FSM for the multicycle MIPS datapath
module multicycle_controller
  import mips_ctrl_pkg::*;
(
  input logic                    clk,
  input logic                    rst_n,
  multicycle_controller_if.master bus
);

  state_e     state_q, state_d;
  logic       pc_write, branch, iord, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a, instr_done, illegal_op;
  logic [1:0] alu_src_b, alu_op, pc_src;

  always_ff @(posedge clk) begin
    if (rst_n) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // rst_n is active-high here; outputs are forced low for the whole reset cycle
  always_comb begin
    state_d    = S_FETCH;
    pc_write   = 1'b0;
    branch     = 1'b0;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    mem_to_reg = 1'b0;
    reg_dst    = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_RT;
    alu_op     = ALUOP_ADD;
    pc_src     = PCSRC_ALU;
    instr_done = 1'b0;
    illegal_op = 1'b0;
    if (!rst_n) begin
      case (state_q)
        S_FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = SRCB_FOUR;
          ir_write  = bus.mem_ready;
          pc_write  = bus.mem_ready;
          state_d   = bus.mem_ready ? S_DECODE : S_FETCH;
        end
        S_DECODE: begin
          alu_src_b = SRCB_IMM_SH;
          case (bus.Opcode)
            OP_LW, OP_SW: state_d = S_MEMADR;
            OP_RTYPE:     state_d = S_EXEC;
            OP_BEQ:       state_d = S_BRANCH;
            OP_ADDI:      state_d = S_ADDIEX;
            OP_J:         state_d = S_JUMP;
            default: begin
              illegal_op = 1'b1;
              instr_done = 1'b1;
              state_d    = S_FETCH;
            end
          endcase
        end
        S_MEMADR: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
          if (bus.Opcode == OP_LW)      state_d = S_MEMRD;
          else if (bus.Opcode == OP_SW) state_d = S_MEMWR;
          else                          state_d = S_FETCH;
        end
        S_MEMRD: begin
          mem_read = 1'b1;
          iord     = 1'b1;
          state_d  = bus.mem_ready ? S_MEMWB : S_MEMRD;
        end
        S_MEMWB: begin
          mem_to_reg = 1'b1;
          reg_write  = 1'b1;
          instr_done = 1'b1;
        end
        S_MEMWR: begin
          mem_write  = 1'b1;
          iord       = 1'b1;
          instr_done = bus.mem_ready;
          state_d    = bus.mem_ready ? S_FETCH : S_MEMWR;
        end
        S_EXEC: begin
          alu_src_a = 1'b1;
          alu_op    = ALUOP_FUNCT;
          state_d   = S_ALUWB;
        end
        S_ALUWB: begin
          reg_dst    = 1'b1;
          reg_write  = 1'b1;
          instr_done = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a  = 1'b1;
          alu_op     = ALUOP_SUB;
          branch     = 1'b1;
          pc_src     = PCSRC_ALUOUT;
          instr_done = 1'b1;
        end
        S_ADDIEX: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
          state_d   = S_ADDIWB;
        end
        S_ADDIWB: begin
          reg_write  = 1'b1;
          instr_done = 1'b1;
        end
        S_JUMP: begin
          pc_write   = 1'b1;
          pc_src     = PCSRC_JUMP;
          instr_done = 1'b1;
        end
        default: state_d = S_FETCH;
      endcase
    end
  end

  assign bus.PCWrite    = pc_write;
  assign bus.Branch     = branch;
  assign bus.IorD       = iord;
  assign bus.MemRead    = mem_read;
  assign bus.MemWrite   = mem_write;
  assign bus.IRWrite    = ir_write;
  assign bus.MemtoReg   = mem_to_reg;
  assign bus.RegDst     = reg_dst;
  assign bus.RegWrite   = reg_write;
  assign bus.ALUSrcA    = alu_src_a;
  assign bus.ALUSrcB    = alu_src_b;
  assign bus.ALUOp      = alu_op;
  assign bus.PCSrc      = pc_src;
  assign bus.instr_done = instr_done;
  assign bus.illegal_op = illegal_op;

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - per-cycle scoreboard bench for multicycle_controller
module tb_multicycle_controller;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  multicycle_controller_if bus ();

  multicycle_controller dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {PCWrite,Branch,IorD,MemRead,MemWrite,IRWrite,MemtoReg,RegDst,RegWrite,
  //  ALUSrcA,ALUSrcB[1:0],ALUOp[1:0],PCSrc[1:0],instr_done,illegal_op}
  logic [17:0] act_vec;
  assign act_vec = {bus.PCWrite, bus.Branch, bus.IorD, bus.MemRead, bus.MemWrite,
                    bus.IRWrite, bus.MemtoReg, bus.RegDst, bus.RegWrite, bus.ALUSrcA,
                    bus.ALUSrcB, bus.ALUOp, bus.PCSrc, bus.instr_done, bus.illegal_op};

  localparam logic [17:0] E_ZERO    = 18'b0_0_0_0_0_0_0_0_0_0_00_00_00_0_0;
  localparam logic [17:0] E_FETCH_R = 18'b1_0_0_1_0_1_0_0_0_0_01_00_00_0_0;
  localparam logic [17:0] E_FETCH_W = 18'b0_0_0_1_0_0_0_0_0_0_01_00_00_0_0;
  localparam logic [17:0] E_DECODE  = 18'b0_0_0_0_0_0_0_0_0_0_11_00_00_0_0;
  localparam logic [17:0] E_ILL     = 18'b0_0_0_0_0_0_0_0_0_0_11_00_00_1_1;
  localparam logic [17:0] E_MEMADR  = 18'b0_0_0_0_0_0_0_0_0_1_10_00_00_0_0;
  localparam logic [17:0] E_MEMRD   = 18'b0_0_1_1_0_0_0_0_0_0_00_00_00_0_0;
  localparam logic [17:0] E_MEMWB   = 18'b0_0_0_0_0_0_1_0_1_0_00_00_00_1_0;
  localparam logic [17:0] E_MEMWR_W = 18'b0_0_1_0_1_0_0_0_0_0_00_00_00_0_0;
  localparam logic [17:0] E_MEMWR_R = 18'b0_0_1_0_1_0_0_0_0_0_00_00_00_1_0;
  localparam logic [17:0] E_EXEC    = 18'b0_0_0_0_0_0_0_0_0_1_00_10_00_0_0;
  localparam logic [17:0] E_ALUWB   = 18'b0_0_0_0_0_0_0_1_1_0_00_00_00_1_0;
  localparam logic [17:0] E_BRANCH  = 18'b0_1_0_0_0_0_0_0_0_1_00_01_01_1_0;
  localparam logic [17:0] E_ADDIEX  = 18'b0_0_0_0_0_0_0_0_0_1_10_00_00_0_0;
  localparam logic [17:0] E_ADDIWB  = 18'b0_0_0_0_0_0_0_0_1_0_00_00_00_1_0;
  localparam logic [17:0] E_JUMP    = 18'b1_0_0_0_0_0_0_0_0_0_00_00_10_1_0;

  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_ADD = 6'b001000;
  localparam logic [5:0] OP_J   = 6'b000010;
  localparam logic [5:0] OP_BAD = 6'b111111;

  logic [17:0] exp_q[$];
  logic [17:0] act_q[$];

  task automatic drive(input logic rst, input logic rdy, input logic [5:0] op,
                       input logic [17:0] expv);
    @(posedge clk);
    #1;
    rst_n         = rst;
    bus.mem_ready = rdy;
    bus.Opcode    = op;
    exp_q.push_back(expv);
    @(negedge clk);
    act_q.push_back(act_vec);
  endtask

  task automatic test_reset();
    logic [17:0] e, a;
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, OP_LW, E_ZERO);
    drive(1'b0, 1'b1, OP_LW, E_FETCH_R);
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); checks++;
      if (a !== e) begin errors++; $display("FAIL reset step %0d: got %b expected %b", i, a, e); end
    end
  endtask

  task automatic test_lw();
    logic [17:0] e, a;
    drive(1'b1, 1'b0, OP_LW, E_ZERO);
    drive(1'b0, 1'b1, OP_LW, E_FETCH_R);
    drive(1'b0, 1'b0, OP_LW, E_DECODE);
    drive(1'b0, 1'b0, OP_LW, E_MEMADR);
    drive(1'b0, 1'b1, OP_LW, E_MEMRD);
    drive(1'b0, 1'b0, OP_LW, E_MEMWB);
    drive(1'b0, 1'b0, OP_LW, E_FETCH_W);
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); checks++;
      if (a !== e) begin errors++; $display("FAIL lw step %0d: got %b expected %b", i, a, e); end
    end
  endtask

  task automatic test_sw_stall();
    logic [17:0] e, a;
    drive(1'b1, 1'b0, OP_SW, E_ZERO);
    drive(1'b0, 1'b1, OP_SW, E_FETCH_R);
    drive(1'b0, 1'b1, OP_SW, E_DECODE);
    drive(1'b0, 1'b1, OP_SW, E_MEMADR);
    drive(1'b0, 1'b0, OP_SW, E_MEMWR_W);
    drive(1'b0, 1'b0, OP_SW, E_MEMWR_W);
    drive(1'b0, 1'b1, OP_SW, E_MEMWR_R);
    drive(1'b0, 1'b0, OP_SW, E_FETCH_W);
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); checks++;
      if (a !== e) begin errors++; $display("FAIL sw_stall step %0d: got %b expected %b", i, a, e); end
    end
  endtask

  task automatic test_fetch_stall();
    logic [17:0] e, a;
    drive(1'b1, 1'b0, OP_J, E_ZERO);
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, OP_J, E_FETCH_W);
    drive(1'b0, 1'b1, OP_J, E_FETCH_R);
    drive(1'b0, 1'b1, OP_J, E_DECODE);
    drive(1'b0, 1'b1, OP_J, E_JUMP);
    drive(1'b0, 1'b0, OP_J, E_FETCH_W);
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); checks++;
      if (a !== e) begin errors++; $display("FAIL fetch_stall step %0d: got %b expected %b", i, a, e); end
    end
  endtask

  task automatic test_back_to_back();
    logic [17:0] e, a;
    drive(1'b1, 1'b0, OP_BEQ, E_ZERO);
    drive(1'b0, 1'b1, OP_BEQ, E_FETCH_R);
    drive(1'b0, 1'b1, OP_BEQ, E_DECODE);
    drive(1'b0, 1'b1, OP_BEQ, E_BRANCH);
    drive(1'b0, 1'b1, OP_J,   E_FETCH_R);
    drive(1'b0, 1'b0, OP_J,   E_DECODE);
    drive(1'b0, 1'b0, OP_J,   E_JUMP);
    drive(1'b0, 1'b1, OP_R,   E_FETCH_R);
    drive(1'b0, 1'b1, OP_R,   E_DECODE);
    drive(1'b0, 1'b1, OP_R,   E_EXEC);
    drive(1'b0, 1'b1, OP_R,   E_ALUWB);
    drive(1'b0, 1'b1, OP_ADD, E_FETCH_R);
    drive(1'b0, 1'b0, OP_ADD, E_DECODE);
    drive(1'b0, 1'b0, OP_ADD, E_ADDIEX);
    drive(1'b0, 1'b0, OP_ADD, E_ADDIWB);
    drive(1'b0, 1'b0, OP_ADD, E_FETCH_W);
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); checks++;
      if (a !== e) begin errors++; $display("FAIL back_to_back step %0d: got %b expected %b", i, a, e); end
    end
  endtask

  task automatic test_illegal_and_abort();
    logic [17:0] e, a;
    drive(1'b1, 1'b0, OP_BAD, E_ZERO);
    drive(1'b0, 1'b1, OP_BAD, E_FETCH_R);
    drive(1'b0, 1'b1, OP_BAD, E_ILL);
    drive(1'b0, 1'b0, OP_LW,  E_FETCH_W);
    drive(1'b0, 1'b1, OP_LW,  E_FETCH_R);
    drive(1'b0, 1'b0, OP_LW,  E_DECODE);
    drive(1'b0, 1'b0, OP_LW,  E_MEMADR);
    drive(1'b0, 1'b0, OP_LW,  E_MEMRD);
    drive(1'b0, 1'b0, OP_LW,  E_MEMRD);
    drive(1'b1, 1'b1, OP_LW,  E_ZERO);
    drive(1'b0, 1'b0, OP_LW,  E_FETCH_W);
    drive(1'b0, 1'b1, OP_LW,  E_FETCH_R);
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); checks++;
      if (a !== e) begin errors++; $display("FAIL illegal_abort step %0d: got %b expected %b", i, a, e); end
    end
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    rst_n         = 1'b1;
    bus.mem_ready = 1'b1;
    bus.Opcode    = OP_LW;
    test_reset();
    test_lw();
    test_sw_stall();
    test_fetch_stall();
    test_back_to_back();
    test_illegal_and_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
